// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus: arbiter state encoding
// and default bus geometry / address map.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_NSLV   = 2;

  // Up to four slaves; slave i occupies bits [i*16 +: 16].
  localparam logic [63:0] DEF_SLV_BASE = {16'h9000, 16'h8000, 16'h7000, 16'h0000};
  localparam logic [63:0] DEF_SLV_MASK = {16'hF000, 16'hF000, 16'hFE00, 16'hF800};

endpackage

// File: rtl/bus_addr_dec.sv
// Mask/base address decoder; produces a one-hot (or zero) slave select,
// lowest slave index winning when windows overlap.
module bus_addr_dec
  import bus_pkg::*;
#(
  parameter int                     ADDR_W   = DEF_ADDR_W,
  parameter int                     NSLV     = DEF_NSLV,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NSLV-1:0]   sel
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    sel = '0;
    if (en) begin
      for (int i = NSLV - 1; i >= 0; i--) begin
        if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arb2.sv
// Two-master bus arbiter with slave decode and one-cycle read return.
// Define BUS_RR_ARB_EN for round-robin contention; default is fixed M0 priority.
//
// state | meaning
// IDLE  | no master granted, forward path driven to zero
// GNT0  | M0 owns the bus until it drops m0_req
// GNT1  | M1 owns the bus until it drops m1_req
module bus_arb2
  import bus_pkg::*;
#(
  parameter int                     DATA_W   = DEF_DATA_W,
  parameter int                     ADDR_W   = DEF_ADDR_W,
  parameter int                     NSLV     = DEF_NSLV,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE[NSLV*ADDR_W-1:0],
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK[NSLV*ADDR_W-1:0]
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   m0_req,
  input  logic                   m0_wr,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [DATA_W-1:0]      m0_dout,
  input  logic                   m1_req,
  input  logic                   m1_wr,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [DATA_W-1:0]      m1_dout,
  output logic                   m0_grant,
  output logic                   m1_grant,
  output logic [DATA_W-1:0]      m_din,
  output logic                   m_err,
  output logic [NSLV-1:0]        s_sel,
  output logic                   s_wr,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_din,
  input  logic [NSLV*DATA_W-1:0] s_dout
);

  arb_state_t      state;
  logic [NSLV-1:0] sel_q;
  logic            grant_any;
`ifdef BUS_RR_ARB_EN
  logic            last_gnt;
`endif

  assign m0_grant  = (state == GNT0);
  assign m1_grant  = (state == GNT1);
  assign grant_any = m0_grant | m1_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sel_q <= '0;
      m_err <= 1'b0;
`ifdef BUS_RR_ARB_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      sel_q <= s_sel;
      m_err <= grant_any && (s_sel == '0);
`ifdef BUS_RR_ARB_EN
      // Lags the grant by a cycle, but contention is only resolved from IDLE.
      if (state == GNT0)      last_gnt <= 1'b0;
      else if (state == GNT1) last_gnt <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (m0_req && m1_req) begin
`ifdef BUS_RR_ARB_EN
            state <= last_gnt ? GNT0 : GNT1;
`else
            state <= GNT0;
`endif
          end else if (m0_req) begin
            state <= GNT0;
          end else if (m1_req) begin
            state <= GNT1;
          end
        end
        GNT0:    if (!m0_req) state <= m1_req ? GNT1 : IDLE;
        GNT1:    if (!m1_req) state <= m0_req ? GNT0 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_addr = '0;
    s_wr   = 1'b0;
    s_din  = '0;
    case (state)
      GNT0: begin
        s_addr = m0_addr;
        s_wr   = m0_wr;
        s_din  = m0_dout;
      end
      GNT1: begin
        s_addr = m1_addr;
        s_wr   = m1_wr;
        s_din  = m1_dout;
      end
      default: ;
    endcase
  end

  bus_addr_dec #(
    .ADDR_W   (ADDR_W),
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_dec (
    .addr (s_addr),
    .en   (grant_any),
    .sel  (s_sel)
  );

  // sel_q is one-hot or zero, so an OR-reduction is an exact mux.
  always_comb begin
    m_din = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) m_din = m_din | s_dout[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Scoreboard bench for bus_arb2: the driver queues hand-computed expected
// bus snapshots, a negedge monitor pops and compares them.
module tb_bus_arb2;

  localparam logic [63:0] D0 = 64'h0F0F;
  localparam logic [63:0] D1 = 64'hF0F0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [15:0]  m0_addr = '0, m1_addr = '0;
  logic [63:0]  m0_dout = '0, m1_dout = '0;
  logic         m0_grant, m1_grant, m_err, s_wr;
  logic [63:0]  m_din, s_din;
  logic [1:0]   s_sel;
  logic [15:0]  s_addr;
  logic [127:0] s_dout;

  assign s_dout = {D1, D0};

  bus_arb2 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_dout  (m0_dout),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_dout  (m1_dout),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m_din    (m_din),
    .m_err    (m_err),
    .s_sel    (s_sel),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_dout   (s_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [86:0] v;  // {g0, g1, sel, wr, addr, din, mdin, err} minus din/mdin split below
    logic [63:0] din;
    logic [63:0] mdin;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  task automatic step(input string name, input logic rst,
                      input logic r0, input logic w0, input logic [15:0] a0, input logic [63:0] d0,
                      input logic r1, input logic w1, input logic [15:0] a1, input logic [63:0] d1,
                      input logic g0, input logic g1, input logic [1:0] sel, input logic wr,
                      input logic [15:0] addr, input logic [63:0] din, input logic [63:0] mdin,
                      input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst;
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_dout = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_dout = d1;
    e.name = name;
    e.v    = {65'd0, g0, g1, sel, wr, addr, err};
    e.din  = din;
    e.mdin = mdin;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [86:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {65'd0, m0_grant, m1_grant, s_sel, s_wr, s_addr, m_err};
      n_cmp++;
      if (act !== e.v || s_din !== e.din || m_din !== e.mdin) begin
        n_bad++;
        $display("FAIL %s: got g0=%b g1=%b sel=%b wr=%b addr=%h din=%h mdin=%h err=%b; want g0=%b g1=%b sel=%b wr=%b addr=%h din=%h mdin=%h err=%b",
                 e.name, m0_grant, m1_grant, s_sel, s_wr, s_addr, s_din, m_din, m_err,
                 e.v[21], e.v[20], e.v[19:18], e.v[17], e.v[16:1], e.din, e.mdin, e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, want end of stimulus");
      $fatal(1, "timeout");
    end
  end

  initial begin
    //   name        rst r0 w0 a0       d0          r1 w1 a1       d1           g0 g1 sel   wr addr     din         mdin err
    step("reset_a",   0, 1, 1, 16'h0000, 64'hFFFF,  1, 1, 16'h7000, 64'hABCD,   0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("reset_b",   0, 1, 1, 16'h0000, 64'hFFFF,  1, 1, 16'h7000, 64'hABCD,   0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("release",   1, 1, 0, 16'h0000, 64'h0,     0, 0, 16'h0000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("m0_grant",  1, 1, 0, 16'h0000, 64'h0,     0, 0, 16'h0000, 64'h0,      1, 0, 2'b01, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("rd_71ff",   1, 1, 0, 16'h71FF, 64'h0,     0, 0, 16'h0000, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     D0,    0);
    step("rd_miss",   1, 1, 0, 16'h6060, 64'h0,     0, 0, 16'h0000, 64'h0,      1, 0, 2'b00, 0, 16'h6060, 64'h0,     D1,    0);
    step("wr_07ff",   1, 1, 1, 16'h07FF, 64'hFFFF,  0, 0, 16'h0000, 64'h0,      1, 0, 2'b01, 1, 16'h07FF, 64'hFFFF,  64'h0, 1);
    step("m1_wait",   1, 1, 0, 16'h71FF, 64'h0,     1, 0, 16'h0010, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     D0,    0);
    step("m1_wait2",  1, 1, 0, 16'h71FF, 64'h0,     1, 0, 16'h0010, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     D1,    0);
    step("m0_drop",   1, 0, 0, 16'h71FF, 64'h0,     1, 0, 16'h0010, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     D1,    0);
    step("handover",  1, 0, 0, 16'h71FF, 64'h0,     1, 0, 16'h0010, 64'h0,      0, 1, 2'b01, 0, 16'h0010, 64'h0,     D1,    0);
    step("m1_wr",     1, 0, 0, 16'h71FF, 64'h0,     1, 1, 16'h7000, 64'hABCD,   0, 1, 2'b10, 1, 16'h7000, 64'hABCD,  D0,    0);
    step("m1_drop",   1, 0, 0, 16'h71FF, 64'h0,     0, 1, 16'h7000, 64'hABCD,   0, 1, 2'b10, 1, 16'h7000, 64'hABCD,  D1,    0);
    step("idle",      1, 0, 0, 16'h0000, 64'h0,     0, 0, 16'h0000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     D1,    0);
    step("both_1",    1, 1, 0, 16'h0000, 64'h0,     1, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("arb_1",     1, 0, 0, 16'h0000, 64'h0,     0, 0, 16'h7000, 64'h0,      1, 0, 2'b01, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("both_2",    1, 1, 0, 16'h0000, 64'h0,     1, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     D0,    0);
`ifdef BUS_RR_ARB_EN
    step("arb_2",     1, 0, 0, 16'h0000, 64'h0,     0, 0, 16'h7000, 64'h0,      0, 1, 2'b10, 0, 16'h7000, 64'h0,     64'h0, 0);
    step("both_3",    1, 1, 0, 16'h0000, 64'h0,     1, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     D1,    0);
`else
    step("arb_2",     1, 0, 0, 16'h0000, 64'h0,     0, 0, 16'h7000, 64'h0,      1, 0, 2'b01, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("both_3",    1, 1, 0, 16'h0000, 64'h0,     1, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     D0,    0);
`endif
    step("arb_3",     1, 1, 0, 16'h71FF, 64'h0,     0, 0, 16'h7000, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     64'h0, 0);
    step("rd_addr",   1, 1, 0, 16'h71FF, 64'h0,     0, 0, 16'h7000, 64'h0,      1, 0, 2'b10, 0, 16'h71FF, 64'h0,     D1,    0);
    step("rst_mid",   0, 1, 0, 16'h71FF, 64'h0,     0, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("rst_rel",   1, 0, 0, 16'h71FF, 64'h0,     0, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    step("after_rel", 1, 0, 0, 16'h71FF, 64'h0,     0, 0, 16'h7000, 64'h0,      0, 0, 2'b00, 0, 16'h0000, 64'h0,     64'h0, 0);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
